// File: rtl/crc_serial_engine.sv
// crc_serial_engine
//
// This is a serial CRC divider. It processes one message bit per clock, MSB
// first, against a generator polynomial that is set at run time.
//
// Generate mode (mode=0):
//   The low CRC_WIDTH bits of msg_in are replaced with zeros.
//   The remainder is then appended to the data bits.
// Check mode (mode=1):
//   The full received codeword is divided.
//   crc_ok reports whether the remainder is zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, only sampled while idle
//   mode       0 = generate, 1 = check
//   msg_in     data in [N-1:CRC_WIDTH] (generate) or full codeword (check)
//   polinom    generator polynomial, MSB first; bit CRC_WIDTH is implied 1
//   busy       high while dividing
//   done       one-cycle pulse when the result registers have just updated
//   msg_output {data, remainder} (generate) or echoed codeword (check)
//   crc_out    final remainder
//   crc_ok     final remainder is zero
module crc_serial_engine #(
  parameter int DATA_WIDTH = 14,
  parameter int CRC_WIDTH  = 3,
  localparam int MSG_LENGTH = DATA_WIDTH + CRC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [MSG_LENGTH-1:0] msg_in,
  input  logic [CRC_WIDTH:0]    polinom,
  output logic                  busy,
  output logic                  done,
  output logic [MSG_LENGTH-1:0] msg_output,
  output logic [CRC_WIDTH-1:0]  crc_out,
  output logic                  crc_ok
);

  localparam int CNT_WIDTH = $clog2(MSG_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_next;
  logic [MSG_LENGTH-1:0] msg_reg;
  logic [MSG_LENGTH-1:0] shift_reg;
  logic [MSG_LENGTH-1:0] msg_load;
  logic [CRC_WIDTH-1:0]  poly_reg;
  logic [CRC_WIDTH-1:0]  rem;
  logic [CRC_WIDTH-1:0]  rem_next;
  logic                  mode_reg;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  last_shift;

  // The leading polynomial coefficient is always 1, so its input bit is never
  // looked at.
  logic unused_poly_msb;
  assign unused_poly_msb = polinom[CRC_WIDTH];

  assign last_shift = (state == SHIFT) && (cnt == CNT_WIDTH'(1));
  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);

  // In generate mode the CRC field is zeroed at load time. This makes the
  // division see the message multiplied by x^CRC_WIDTH.
  assign msg_load = mode ? msg_in
                         : {msg_in[MSG_LENGTH-1:CRC_WIDTH], {CRC_WIDTH{1'b0}}};

  // One long-division step. Shift the next message bit into the remainder.
  // If the bit that falls out of the top is set, subtract (xor) the polynomial.
  generate
    if (CRC_WIDTH == 1) begin : g_rem1
      assign rem_next = shift_reg[MSG_LENGTH-1] ^ (rem[0] & poly_reg[0]);
    end else begin : g_remn
      assign rem_next = {rem[CRC_WIDTH-2:0], shift_reg[MSG_LENGTH-1]}
                        ^ (rem[CRC_WIDTH-1] ? poly_reg : {CRC_WIDTH{1'b0}});
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_WIDTH'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched when a request is accepted. Later changes on the
  // inputs therefore cannot disturb a division that is already running.
  // The result registers are loaded on the final shift edge, using the
  // remainder that this edge produces. They are valid during the DONE cycle
  // and keep their values until the next operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_reg    <= '0;
      shift_reg  <= '0;
      poly_reg   <= '0;
      mode_reg   <= 1'b0;
      rem        <= '0;
      cnt        <= '0;
      msg_output <= '0;
      crc_out    <= '0;
      crc_ok     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        msg_reg   <= msg_load;
        shift_reg <= msg_load;
        poly_reg  <= polinom[CRC_WIDTH-1:0];
        mode_reg  <= mode;
        rem       <= '0;
        cnt       <= CNT_WIDTH'(MSG_LENGTH);
      end else if (state == SHIFT) begin
        rem       <= rem_next;
        shift_reg <= shift_reg << 1;
        cnt       <= cnt - CNT_WIDTH'(1);
        if (last_shift) begin
          crc_out    <= rem_next;
          crc_ok     <= (rem_next == '0);
          msg_output <= mode_reg ? msg_reg
                                 : {msg_reg[MSG_LENGTH-1:CRC_WIDTH], rem_next};
        end
      end
    end
  end

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised serial CRC engine: generalises our fixed CRC-3 / 14-bit-message block to any data width and CRC degree, with a runtime polynomial. It divides one bit per clock, MSB first. In generate mode it appends the remainder to the data. In check mode it verifies a received codeword. It sits between the message source and the link/transmit logic and uses a start/busy/done handshake.

## Interface
Parameters:
- DATA_WIDTH, 14, user data bits per message (≥1)
- CRC_WIDTH, 3, CRC degree = remainder width (≥1)
- MSG_LENGTH (local), DATA_WIDTH+CRC_WIDTH, codeword width N

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = generate, 1 = check
- msg_in  in  MSG_LENGTH  generate: data in [N-1:CRC_WIDTH], low CRC_WIDTH bits forced to 0 internally; check: full codeword
- polinom  in  CRC_WIDTH+1  generator polynomial, MSB first; bit CRC_WIDTH treated as 1 regardless of input
- busy  out  1  high while dividing
- done  out  1  one-cycle pulse when results update
- msg_output  out  MSG_LENGTH  generate: {data, remainder}; check: codeword echoed
- crc_out  out  CRC_WIDTH  final remainder
- crc_ok  out  1  remainder == 0

## Operation
- States: IDLE → SHIFT → DONE → IDLE.
- IDLE + start=1:
  - latch msg_in (low CRC_WIDTH bits zeroed if mode=0), polinom and mode
  - clear remainder R (CRC_WIDTH bits)
  - load bit counter with N; go to SHIFT
- SHIFT, each cycle:
  - b = next message bit, MSB first; f = R[CRC_WIDTH-1]
  - R ← {R[CRC_WIDTH-2:0], b} ^ (f ? polinom[CRC_WIDTH-1:0] : 0); for CRC_WIDTH=1, R ← b ^ (f & polinom[0])
  - decrement counter; go to DONE after the N-th shift
- DONE (one cycle):
  - done=1; crc_out ← R; crc_ok ← (R==0)
  - msg_output ← {latched data, R} in generate mode, latched codeword in check mode
  - next state IDLE
- start in SHIFT or DONE is ignored and not queued.
- msg_in, polinom and mode changes after the start cycle have no effect on the running operation.
- Outputs hold their values until the next DONE update.
- Counter width: $clog2(N+1).

## Timing
- Reset (async, any state including mid-SHIFT): state=IDLE, busy=0, done=0, msg_output=0, crc_out=0, crc_ok=0, R=0, counter=0. The operation in progress is abandoned.
- Reset release: start is honoured on the first rising edge with rst=0.
- Start accepted at edge T: busy=1 from T through T+N (N cycles).
- Edge T+N: done=1 and outputs valid for the cycle after edge T+N; busy=0 in that cycle.
- Latency start→done = N+1 cycles; default N=17 gives 18.
- Earliest next accepted start: the edge after done (one cycle after DONE). Back-to-back throughput is one message per N+2 cycles.
- start held high continuously: a new operation begins each time the FSM returns to IDLE.
- polinom = 0 in low bits (P=x^CRC_WIDTH): legal; the remainder equals the last CRC_WIDTH message bits.

## Test plan
- Defaults, mode=0, msg_in=17'b11010011101100000, polinom=4'b1011, start pulse
  - required: done exactly 18 cycles later; crc_out=3'b100; msg_output=17'b11010011101100100; crc_ok=0
- Defaults, mode=1, msg_in=17'b11010011101100100
  - required: crc_out=3'b000, crc_ok=1, msg_output equals input
- Same codeword with bit 9 flipped
  - required: crc_ok=0, crc_out≠0
- DATA_WIDTH=8, CRC_WIDTH=8, polinom=9'h107, mode=0
  - data 8'h01: crc_out=8'h07, msg_output=16'h0107
  - data 8'h00: crc_out=8'h00
  - then check mode on 16'h0107: crc_ok=1
- Robustness
  - start pulsed mid-SHIFT, and msg_in/polinom changed mid-SHIFT: result unchanged from the first operation and only one done pulse
  - rst asserted at shift 8: all outputs 0 immediately; the next start produces a correct result with full latency
- start held high for 60 cycles on defaults
  - required: done pulses every 19 cycles, all with crc_out=3'b100, busy never overlaps done
